dom_share_gen_d1: RTL and testbench
===================================

DOM_SHARE_GEN_D1 -- requirements
Module: dom_share_gen_d1

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port port_seed, input, 32, PRNG seed value.
REQ-004 SHALL have port port_seed_valid, input, 1, load port_seed this cycle.
REQ-005 SHALL have port port_in_a, input, 1, unmasked operand a.
REQ-006 SHALL have port port_in_b, input, 1, unmasked operand b.
REQ-007 SHALL have port port_in_valid, input, 1, operand pair offered.
REQ-008 SHALL have port port_in_ready, output, 1, operand pair accepted when high together with port_in_valid.
REQ-009 SHALL have port port_a, output, 2, first-order Boolean shares of a.
REQ-010 SHALL have port port_b, output, 2, first-order Boolean shares of b.
REQ-011 SHALL have port port_r, output, 1, fresh mask for the downstream DOM-indep AND gadget.
REQ-012 SHALL have port port_out_valid, output, 1, port_a/port_b/port_r hold a valid share set.
REQ-013 SHALL have port port_out_ready, input, 1, downstream consumes share set when high together with port_out_valid.
REQ-014 SHALL have port port_seeded, output, 1, PRNG holds a loaded seed.

Function
REQ-015 SHALL keep a 32-bit Galois LFSR s with step nxt(s) = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0).
REQ-016 SHALL use two states: UNSEEDED (port_seeded=0, port_in_ready=0) and RUN (port_seeded=1); UNSEEDED -> RUN on port_seed_valid; RUN is left only by reset.
REQ-017 SHALL load s <= port_seed on port_seed_valid; a seed of 0 SHALL be replaced by 32'h0000_0001.
REQ-018 SHALL drive port_in_ready = RUN && !port_seed_valid && (!port_out_valid || port_out_ready).
REQ-019 SHALL, on acceptance, set s <= n = nxt(s); bits m_a = n[0], m_b = n[1], r = n[2].
REQ-020 SHALL register on acceptance: port_a[0]=m_a, port_a[1]=in_a^m_a, port_b[0]=m_b, port_b[1]=in_b^m_b, port_r=r; port_out_valid=1 the following cycle (latency 1).
REQ-021 SHALL hold all outputs stable while port_out_valid && !port_out_ready.
REQ-022 SHALL clear port_out_valid after consumption when no new pair is accepted in the same cycle; consume and accept in one cycle SHALL give back-to-back output with no bubble.
REQ-023 SHALL advance s only on acceptance or seed load; seed load wins over acceptance in the same cycle.
REQ-024 SHALL leave a pending output untouched by a mid-run reseed; the new seed applies from the next acceptance.

Reset
REQ-025 SHALL on rst set state UNSEEDED, s=32'h0000_0001, port_out_valid=0, port_a=0, port_b=0, port_r=0, port_seeded=0; rst overrides port_seed_valid.
REQ-026 SHALL drop any pending output on rst mid-operation without emitting it.

Configuration
REQ-027 SHALL with DOM_SHARE_USAGE_CNT_EN defined add output port_used[15:0]: count of accepted pairs since last seed load, saturating at 16'hFFFF, cleared by rst and seed load.
REQ-028 SHALL without DOM_SHARE_USAGE_CNT_EN omit port_used and its counter; all other behaviour identical.

Verification
REQ-029 SHALL cover: after reset, port_in_valid=1 with no seed -> port_in_ready=0, port_out_valid stays 0.
REQ-030 SHALL cover: seed 0x00000001, then in_a=1, in_b=0 accepted -> next cycle port_a=2'b01, port_b=2'b11, port_r=0, s=0x80200003.
REQ-031 SHALL cover: second pair in_a=0, in_b=1 immediately after, port_out_ready=1 -> port_a=2'b00, port_b=2'b01, port_r=0, s=0xC0300002, no bubble.
REQ-032 SHALL cover: port_out_ready=0 for 5 cycles with port_in_valid=1 -> outputs stable, port_in_ready=0, s unchanged.
REQ-033 SHALL cover: seed 0x00000000 -> identical outputs to seed 0x00000001; seed_valid with in_valid same cycle -> input not accepted.
REQ-034 SHALL cover (DOM_SHARE_USAGE_CNT_EN): 70000 acceptances -> port_used=16'hFFFF; reseed -> port_used=0.

Source files
------------

// File: rtl/dom_share_gen_d1.sv
// dom_share_gen_d1: splits an unmasked operand pair (a, b) into first-order
// Boolean shares and supplies one fresh mask bit for a downstream DOM-indep
// AND gadget. Randomness comes from a 32-bit Galois LFSR that must be seeded
// before any pair is accepted. Output is a single registered stage with a
// valid/ready handshake on each side.
//
// Optional feature: define DOM_SHARE_USAGE_CNT_EN to add port_used, a
// saturating count of pairs accepted since the last seed load.
module dom_share_gen_d1 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] port_seed,
    input  logic        port_seed_valid,
    input  logic        port_in_a,
    input  logic        port_in_b,
    input  logic        port_in_valid,
    output logic        port_in_ready,
    output logic [1:0]  port_a,
    output logic [1:0]  port_b,
    output logic        port_r,
    output logic        port_out_valid,
    input  logic        port_out_ready,
    output logic        port_seeded
`ifdef DOM_SHARE_USAGE_CNT_EN
    ,
    output logic [15:0] port_used
`endif
);

    localparam logic [31:0] LfsrPoly = 32'h8020_0003;
    localparam logic [31:0] LfsrInit = 32'h0000_0001;

    typedef enum logic [0:0] {
        StUnseeded,
        StRun
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] lfsr_nxt;
    logic [1:0]  a_q, a_d;
    logic [1:0]  b_q, b_d;
    logic        r_q, r_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready;
    logic        accept;

    // Handshake: a seed load blocks acceptance so the load always wins.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'h0);
        in_ready = (state_q == StRun) && !port_seed_valid &&
                   (!out_valid_q || port_out_ready);
        accept   = port_in_valid && in_ready;
    end

    // Next-state for FSM, LFSR and the output share register.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;

        if (port_seed_valid) begin
            state_d = StRun;
            // An all-zero state would lock the LFSR up.
            lfsr_d  = (port_seed == 32'h0) ? LfsrInit : port_seed;
        end else if (accept) begin
            lfsr_d = lfsr_nxt;
        end

        // A reseed never touches a pending share set.
        if (accept) begin
            a_d         = {port_in_a ^ lfsr_nxt[0], lfsr_nxt[0]};
            b_d         = {port_in_b ^ lfsr_nxt[1], lfsr_nxt[1]};
            r_d         = lfsr_nxt[2];
            out_valid_d = 1'b1;
        end else if (out_valid_q && port_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset overrides a seed load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StUnseeded;
            lfsr_q      <= LfsrInit;
            a_q         <= 2'b00;
            b_q         <= 2'b00;
            r_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DOM_SHARE_USAGE_CNT_EN
    logic [15:0] used_q, used_d;

    // Saturating count of accepted pairs since the last seed load.
    always_comb begin
        used_d = used_q;
        if (port_seed_valid) begin
            used_d = 16'h0000;
        end else if (accept && (used_q != 16'hFFFF)) begin
            used_d = used_q + 16'h0001;
        end
    end

    // Usage counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= 16'h0000;
        end else begin
            used_q <= used_d;
        end
    end

    assign port_used = used_q;
`endif

    assign port_in_ready  = in_ready;
    assign port_a         = a_q;
    assign port_b         = b_q;
    assign port_r         = r_q;
    assign port_out_valid = out_valid_q;
    assign port_seeded    = (state_q == StRun);

endmodule

// File: tb/tb_dom_share_gen_d1.sv
// Directed bench for dom_share_gen_d1. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after the edge (registered) or 1 ns after
// an input change (combinational port_in_ready).
module tb_dom_share_gen_d1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] port_seed;
    logic        port_seed_valid;
    logic        port_in_a;
    logic        port_in_b;
    logic        port_in_valid;
    logic        port_in_ready;
    logic [1:0]  port_a;
    logic [1:0]  port_b;
    logic        port_r;
    logic        port_out_valid;
    logic        port_out_ready;
    logic        port_seeded;
`ifdef DOM_SHARE_USAGE_CNT_EN
    logic [15:0] port_used;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dom_share_gen_d1 dut (
        .clk             (clk),
        .rst             (rst),
        .port_seed       (port_seed),
        .port_seed_valid (port_seed_valid),
        .port_in_a       (port_in_a),
        .port_in_b       (port_in_b),
        .port_in_valid   (port_in_valid),
        .port_in_ready   (port_in_ready),
        .port_a          (port_a),
        .port_b          (port_b),
        .port_r          (port_r),
        .port_out_valid  (port_out_valid),
        .port_out_ready  (port_out_ready),
        .port_seeded     (port_seeded)
`ifdef DOM_SHARE_USAGE_CNT_EN
        ,
        .port_used       (port_used)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; port_seed = 32'h0; port_seed_valid = 1'b0;
        port_in_a = 1'b0; port_in_b = 1'b0; port_in_valid = 1'b0; port_out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if (port_seeded !== 1'b0) begin
            n_fail++; $display("FAIL reset_seeded got %b want 0", port_seeded);
        end
        n_checks++;
        if ({port_a, port_b, port_r, port_out_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want 000000",
                               {port_a, port_b, port_r, port_out_valid});
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h0000_0001) begin
            n_fail++; $display("FAIL reset_lfsr got %h want 00000001", dut.lfsr_q);
        end
        // Unseeded: offered pairs must be refused.
        port_in_valid = 1'b1; port_in_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (port_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL unseeded_ready cyc %0d got %b want 0", i, port_in_ready);
            end
            tick();
            n_checks++;
            if (port_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL unseeded_valid cyc %0d got %b want 0", i, port_out_valid);
            end
        end
        port_in_valid = 1'b0;
    endtask

    task automatic test_first_pair();
        port_seed = 32'h0000_0001; port_seed_valid = 1'b1;
        tick();
        port_seed_valid = 1'b0;
        n_checks++;
        if (port_seeded !== 1'b1) begin
            n_fail++; $display("FAIL seeded got %b want 1", port_seeded);
        end
        port_in_a = 1'b1; port_in_b = 1'b0; port_in_valid = 1'b1; port_out_ready = 1'b1;
        #1;
        n_checks++;
        if (port_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL first_ready got %b want 1", port_in_ready);
        end
        tick();
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b01, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL first_shares got v%b a%b b%b r%b want v1 a01 b11 r0",
                               port_out_valid, port_a, port_b, port_r);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h8020_0003) begin
            n_fail++; $display("FAIL first_lfsr got %h want 80200003", dut.lfsr_q);
        end
    endtask

    task automatic test_back_to_back();
        port_in_a = 1'b0; port_in_b = 1'b1; port_in_valid = 1'b1; port_out_ready = 1'b1;
        #1;
        n_checks++;
        if (port_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready got %b want 1", port_in_ready);
        end
        tick();
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b00, 2'b01, 1'b0}) begin
            n_fail++; $display("FAIL b2b_shares got v%b a%b b%b r%b want v1 a00 b01 r0",
                               port_out_valid, port_a, port_b, port_r);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'hC030_0002) begin
            n_fail++; $display("FAIL b2b_lfsr got %h want c0300002", dut.lfsr_q);
        end
    endtask

    task automatic test_backpressure();
        port_out_ready = 1'b0; port_in_valid = 1'b1; port_in_a = 1'b1; port_in_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (port_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0", i, port_in_ready);
            end
            tick();
            n_checks++;
            if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b00, 2'b01, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold cyc %0d got v%b a%b b%b r%b want v1 a00 b01 r0",
                                   i, port_out_valid, port_a, port_b, port_r);
            end
            n_checks++;
            if (dut.lfsr_q !== 32'hC030_0002) begin
                n_fail++; $display("FAIL bp_lfsr cyc %0d got %h want c0300002", i, dut.lfsr_q);
            end
        end
        // Drain with nothing offered: valid must drop.
        port_in_valid = 1'b0; port_out_ready = 1'b1;
        tick();
        n_checks++;
        if (port_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid got %b want 0", port_out_valid);
        end
    endtask

    task automatic test_reseed_pending();
        // nxt(c0300002) = 60180001 -> m_a=1, m_b=0, r=0
        port_in_a = 1'b1; port_in_b = 1'b1; port_in_valid = 1'b1; port_out_ready = 1'b0;
        tick();
        port_in_valid = 1'b0;
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b01, 2'b10, 1'b0}) begin
            n_fail++; $display("FAIL pend_shares got v%b a%b b%b r%b want v1 a01 b10 r0",
                               port_out_valid, port_a, port_b, port_r);
        end
        port_seed = 32'h1234_5678; port_seed_valid = 1'b1;
        tick();
        port_seed_valid = 1'b0;
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b01, 2'b10, 1'b0}) begin
            n_fail++; $display("FAIL reseed_hold got v%b a%b b%b r%b want v1 a01 b10 r0",
                               port_out_valid, port_a, port_b, port_r);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h1234_5678) begin
            n_fail++; $display("FAIL reseed_lfsr got %h want 12345678", dut.lfsr_q);
        end
        // nxt(12345678) = 091a2b3c -> m_a=0, m_b=0, r=1
        port_out_ready = 1'b1; port_in_valid = 1'b1;
        tick();
        port_in_valid = 1'b0; port_out_ready = 1'b0;
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b10, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL reseed_shares got v%b a%b b%b r%b want v1 a10 b10 r1",
                               port_out_valid, port_a, port_b, port_r);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h091A_2B3C) begin
            n_fail++; $display("FAIL reseed_next got %h want 091a2b3c", dut.lfsr_q);
        end
    endtask

    task automatic test_reset_mid();
        // Pending output is present; reset (with a concurrent seed) drops it.
        rst = 1'b1; port_seed = 32'hDEAD_BEEF; port_seed_valid = 1'b1;
        tick();
        rst = 1'b0; port_seed_valid = 1'b0;
        n_checks++;
        if ({port_seeded, port_out_valid, port_a, port_b, port_r} !== 7'b0) begin
            n_fail++; $display("FAIL midrst_outputs got s%b v%b a%b b%b r%b want all 0",
                               port_seeded, port_out_valid, port_a, port_b, port_r);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h0000_0001) begin
            n_fail++; $display("FAIL midrst_lfsr got %h want 00000001", dut.lfsr_q);
        end
    endtask

    task automatic test_zero_seed();
        port_seed = 32'h0; port_seed_valid = 1'b1;
        port_in_a = 1'b1; port_in_b = 1'b0; port_in_valid = 1'b1; port_out_ready = 1'b1;
        #1;
        tick();
        port_seed_valid = 1'b0;
        n_checks++;
        if (port_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL seed_blocks_accept got %b want 0", port_out_valid);
        end
        n_checks++;
        if (dut.lfsr_q !== 32'h0000_0001) begin
            n_fail++; $display("FAIL zero_seed_lfsr got %h want 00000001", dut.lfsr_q);
        end
        tick();
        port_in_valid = 1'b0;
        n_checks++;
        if ({port_out_valid, port_a, port_b, port_r} !== {1'b1, 2'b01, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL zero_seed_shares got v%b a%b b%b r%b want v1 a01 b11 r0",
                               port_out_valid, port_a, port_b, port_r);
        end
        tick();
        n_checks++;
        if (port_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL zero_seed_drain got %b want 0", port_out_valid);
        end
    endtask

`ifdef DOM_SHARE_USAGE_CNT_EN
    task automatic test_usage_cnt();
        port_seed = 32'hACE1_0001; port_seed_valid = 1'b1;
        tick();
        port_seed_valid = 1'b0;
        n_checks++;
        if (port_used !== 16'h0000) begin
            n_fail++; $display("FAIL used_after_seed got %h want 0000", port_used);
        end
        port_in_valid = 1'b1; port_out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            port_in_a = i[0]; port_in_b = i[1];
            tick();
        end
        port_in_valid = 1'b0;
        n_checks++;
        if (port_used !== 16'hFFFF) begin
            n_fail++; $display("FAIL used_saturate got %h want ffff", port_used);
        end
        port_seed_valid = 1'b1;
        tick();
        port_seed_valid = 1'b0;
        n_checks++;
        if (port_used !== 16'h0000) begin
            n_fail++; $display("FAIL used_reseed got %h want 0000", port_used);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_pair();
        test_back_to_back();
        test_backpressure();
        test_reseed_pending();
        test_reset_mid();
        test_zero_seed();
`ifdef DOM_SHARE_USAGE_CNT_EN
        test_usage_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
